// File: rtl/clk_rst_supervisor_if.sv
// Handshake bundle between the DCM-side supervisor and its environment.
// slave = supervisor view, master = DCM/system side view.
interface clk_rst_supervisor_if;
  logic       dcm_locked;
  logic [7:0] dcm_status;
  logic       dcm_reset;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [7:0] retry_count;

  modport master (
    output dcm_locked, dcm_status,
    input  dcm_reset, sys_rst, ready, fault, retry_count
  );

  modport slave (
    input  dcm_locked, dcm_status,
    output dcm_reset, sys_rst, ready, fault, retry_count
  );
endinterface

// File: rtl/clk_rst_supervisor.sv
// DCM reset/lock supervisor: pulses DCM reset, waits for stable lock, releases sys_rst, retries on loss.
// Optional macro CLKFX_STOP_DETECT_EN: treat synchronized STATUS[2:1] != 0 as lock loss in S_STABLE/S_RUN.
module clk_rst_supervisor #(
  parameter int unsigned RST_PULSE_CYCLES    = 8,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 33000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 4,
  parameter int unsigned CNT_W               = 16
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  clk_rst_supervisor_if.slave    bus
);

  localparam int unsigned BUD_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [BUD_W-1:0] BUDGET_MAX   = BUD_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [BUD_W-1:0] budget_reg, budget_next, budget_inc;
  logic [7:0]       retry_reg, retry_next;
  logic             locked_meta_reg, locked_s_reg;
  logic             loss;
  logic             do_retry;
  logic             dcm_reset_reg, sys_rst_reg, ready_reg, fault_reg;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      locked_meta_reg <= 1'b0;
      locked_s_reg    <= 1'b0;
    end else begin
      locked_meta_reg <= bus.dcm_locked;
      locked_s_reg    <= locked_meta_reg;
    end
  end

`ifdef CLKFX_STOP_DETECT_EN
  logic [1:0] stop_meta_reg, stop_s_reg;
  wire        unused_status = ^{bus.dcm_status[7:3], bus.dcm_status[0]};

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      stop_meta_reg <= 2'b00;
      stop_s_reg    <= 2'b00;
    end else begin
      stop_meta_reg <= bus.dcm_status[2:1];
      stop_s_reg    <= stop_meta_reg;
    end
  end

  assign loss = !locked_s_reg || (stop_s_reg != 2'b00);
`else
  wire unused_status = ^bus.dcm_status;

  assign loss = !locked_s_reg;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_RESET;
      timer_reg  <= '0;
      budget_reg <= '0;
      retry_reg  <= 8'd0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      budget_reg <= budget_next;
      retry_reg  <= retry_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg + CNT_W'(1);
    budget_inc  = budget_reg + BUD_W'(1);
    budget_next = budget_reg;
    retry_next  = retry_reg;
    do_retry    = 1'b0;

    case (state_reg)
      S_RESET: begin
        if (timer_reg == PULSE_LAST) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock seen on the timeout cycle still counts as a lock.
        if (locked_s_reg)                   state_next = S_STABLE;
        else if (timer_reg == TIMEOUT_LAST) do_retry   = 1'b1;
      end
      S_STABLE: begin
        if (loss) begin
          do_retry = 1'b1;
        end else if (timer_reg == STABLE_LAST) begin
          state_next  = S_RUN;
          budget_next = '0;
        end
      end
      S_RUN: begin
        timer_next = timer_reg;
        if (loss) do_retry = 1'b1;
      end
      S_FAULT: begin
        timer_next = timer_reg;
      end
      default: begin
        state_next = S_RESET;
      end
    endcase

    if (do_retry) begin
      retry_next  = (retry_reg == 8'hFF) ? retry_reg : retry_reg + 8'd1;
      budget_next = budget_inc;
      state_next  = ((MAX_RETRIES != 0) && (budget_inc == BUDGET_MAX)) ? S_FAULT : S_RESET;
    end

    if (state_next != state_reg) timer_next = '0;
  end

  // Outputs are decoded from the next state so they move on the same edge as the state.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      dcm_reset_reg <= 1'b1;
      sys_rst_reg   <= 1'b1;
      ready_reg     <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      dcm_reset_reg <= (state_next == S_RESET) || (state_next == S_FAULT);
      sys_rst_reg   <= (state_next != S_RUN);
      ready_reg     <= (state_next == S_RUN);
      fault_reg     <= (state_next == S_FAULT);
    end
  end

  assign bus.dcm_reset   = dcm_reset_reg;
  assign bus.sys_rst     = sys_rst_reg;
  assign bus.ready       = ready_reg;
  assign bus.fault       = fault_reg;
  assign bus.retry_count = retry_reg;

endmodule

// File: tb/tb_clk_rst_supervisor.sv
// Bench for clk_rst_supervisor: per-cycle reference model plus directed literal checks.
// Build with CLKFX_STOP_DETECT_EN defined to exercise the STATUS stop path.
module tb_clk_rst_supervisor;

  localparam int RP = 4;
  localparam int LT = 20;
  localparam int SC = 8;
  localparam int MR = 2;
`ifdef CLKFX_STOP_DETECT_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  localparam int P_PULSE = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAULT = 4;

  logic clk_sys;
  logic rst_n;
  bit   clk_en = 1'b1;

  clk_rst_supervisor_if bus_if ();

  clk_rst_supervisor #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_TIMEOUT_CYCLES(LT),
    .STABLE_CYCLES      (SC),
    .MAX_RETRIES        (MR),
    .CNT_W              (16)
  ) dut (
    .clk_sys(clk_sys),
    .rst_n  (rst_n),
    .bus    (bus_if.slave)
  );

  initial begin
    clk_sys = 1'b0;
    forever #15 if (clk_en) clk_sys = ~clk_sys;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: countdowns of remaining cycles per phase, 2-deep sample history for the synchronizers.
  int         m_phase, m_left, m_retries, m_budget;
  bit         lk_hist[$];
  logic [1:0] st_hist[$];

  task automatic model_reset();
    m_phase   = P_PULSE;
    m_left    = RP;
    m_retries = 0;
    m_budget  = 0;
    lk_hist   = '{1'b0, 1'b0};
    st_hist   = '{2'b00, 2'b00};
  endtask

  task automatic model_step(input bit lk_in, input logic [1:0] st_in);
    bit         lk;
    logic [1:0] st;
    bit         loss;
    bit         retry;
    lk = lk_hist.pop_front();
    lk_hist.push_back(lk_in);
    st = st_hist.pop_front();
    st_hist.push_back(st_in);
    loss  = !lk || (STOP_EN && (st != 2'b00));
    retry = 1'b0;
    case (m_phase)
      P_PULSE: begin
        m_left--;
        if (m_left == 0) begin m_phase = P_WAIT; m_left = LT; end
      end
      P_WAIT: begin
        if (lk) begin
          m_phase = P_STAB; m_left = SC;
        end else begin
          m_left--;
          if (m_left == 0) retry = 1'b1;
        end
      end
      P_STAB: begin
        if (loss) retry = 1'b1;
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = P_RUN; m_budget = 0; end
        end
      end
      P_RUN: if (loss) retry = 1'b1;
      default: ;
    endcase
    if (retry) begin
      if (m_retries < 255) m_retries++;
      m_budget++;
      m_phase = (MR != 0 && m_budget == MR) ? P_FAULT : P_PULSE;
      m_left  = RP;
    end
  endtask

  function automatic int expected_vec();
    logic [11:0] v;
    v = {(m_phase == P_PULSE) || (m_phase == P_FAULT), m_phase != P_RUN,
         m_phase == P_RUN, m_phase == P_FAULT, 8'(m_retries)};
    return int'(v);
  endfunction

  function automatic int actual_vec();
    logic [11:0] v;
    v = {bus_if.dcm_reset, bus_if.sys_rst, bus_if.ready, bus_if.fault, bus_if.retry_count};
    return int'(v);
  endfunction

  // Per-cycle compare: inputs sampled at the edge, outputs checked 1 time unit later.
  initial begin
    bit         r, lk;
    logic [1:0] st;
    model_reset();
    forever begin
      @(posedge clk_sys);
      r  = rst_n;
      lk = bus_if.dcm_locked;
      st = bus_if.dcm_status[2:1];
      #1;
      if (!r || !rst_n) model_reset();
      else model_step(lk, st);
      chk("cycle_outputs", actual_vec(), expected_vec());
    end
  end

  task automatic reset_release();
    @(negedge clk_sys);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  task automatic count_pulse(output int cnt);
    cnt = 0;
    while (bus_if.dcm_reset && cnt < 20) begin
      cnt++;
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wait_ready(input int limit);
    int n;
    n = 0;
    while (!bus_if.ready && n < limit) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
  endtask

  initial begin
    int cnt, n;
    bit saw_low;
    rst_n = 1'b1;
    bus_if.dcm_locked = 1'b0;
    bus_if.dcm_status = 8'h00;
    #2 rst_n = 1'b0;
    #3;
    chk("por_dcm_reset", bus_if.dcm_reset, 1);
    chk("por_sys_rst", bus_if.sys_rst, 1);
    chk("por_ready", bus_if.ready, 0);
    chk("por_fault", bus_if.fault, 0);
    chk("por_retry_count", bus_if.retry_count, 0);

    // Nominal bring-up: lock rises 10 cycles after release.
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    #1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.dcm_reset) cnt++;
      @(negedge clk_sys);
    end
    chk("nom_pulse_len", cnt, 4);
    bus_if.dcm_locked = 1'b1;
    n = 0;
    while (n < 30) begin
      @(posedge clk_sys);
      #1;
      n++;
      if (!bus_if.sys_rst) break;
    end
    // 2 sync edges, 1 edge into S_STABLE, 8 stable edges.
    chk("nom_release_edges", n, 11);
    chk("nom_ready", bus_if.ready, 1);
    chk("nom_retry_count", bus_if.retry_count, 0);
    $display("txn nominal: pulse=%0d release_edges=%0d", cnt, n);

    // Lock loss while running, relock, then budget check.
    repeat (3) @(negedge clk_sys);
    bus_if.dcm_locked = 1'b0;
    n = 0;
    while (n < 10) begin
      @(posedge clk_sys);
      #1;
      n++;
      if (bus_if.sys_rst) break;
    end
    chk("run_loss_edges", n, 3);
    chk("run_loss_ready", bus_if.ready, 0);
    count_pulse(cnt);
    chk("run_loss_pulse_len", cnt, 4);
    @(negedge clk_sys);
    bus_if.dcm_locked = 1'b1;
    wait_ready(40);
    chk("relock_ready", bus_if.ready, 1);
    chk("relock_retry_count", bus_if.retry_count, 1);
    $display("txn run_loss: loss_edges=%0d pulse=%0d retries=%0d", n, cnt, bus_if.retry_count);
    @(negedge clk_sys);
    bus_if.dcm_locked = 1'b0;
    n = 0;
    while (!bus_if.fault && n < 80) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
    chk("budget_fault", bus_if.fault, 1);
    chk("budget_retry_count", bus_if.retry_count, 3);
    $display("txn budget: fault after %0d edges", n);

    // Never locks: two timed-out attempts then fault.
    reset_release();
    repeat (47) @(negedge clk_sys);
    chk("nolock_fault_early", bus_if.fault, 0);
    @(negedge clk_sys);
    chk("nolock_fault", bus_if.fault, 1);
    chk("nolock_retry_count", bus_if.retry_count, 2);
    bus_if.dcm_locked = 1'b1;
    repeat (6) @(negedge clk_sys);
    chk("fault_hold_dcm_reset", bus_if.dcm_reset, 1);
    chk("fault_hold_sys_rst", bus_if.sys_rst, 1);
    bus_if.dcm_locked = 1'b0;
    $display("txn never_locks: fault=%0d retries=%0d", bus_if.fault, bus_if.retry_count);

    // Lock drops after 5 stable cycles.
    reset_release();
    repeat (6) @(negedge clk_sys);
    bus_if.dcm_locked = 1'b1;
    saw_low = 1'b0;
    repeat (6) begin
      @(negedge clk_sys);
      if (!bus_if.sys_rst) saw_low = 1'b1;
    end
    bus_if.dcm_locked = 1'b0;
    n = 0;
    while (!bus_if.dcm_reset && n < 20) begin
      @(posedge clk_sys);
      #1;
      if (!bus_if.sys_rst) saw_low = 1'b1;
      n++;
    end
    count_pulse(cnt);
    chk("early_drop_pulse_len", cnt, 4);
    chk("early_drop_retry_count", bus_if.retry_count, 1);
    chk("early_drop_sys_rst_held", saw_low, 0);
    $display("txn early_drop: pulse=%0d retries=%0d", cnt, bus_if.retry_count);

    // Asynchronous reset in S_WAIT_LOCK with the clock stopped.
    @(negedge clk_sys);
    clk_en = 1'b0;
    #7 rst_n = 1'b0;
    #2;
    chk("async_dcm_reset", bus_if.dcm_reset, 1);
    chk("async_sys_rst", bus_if.sys_rst, 1);
    chk("async_ready", bus_if.ready, 0);
    chk("async_fault", bus_if.fault, 0);
    chk("async_retry_count", bus_if.retry_count, 0);
    #20 clk_en = 1'b1;
    repeat (2) @(negedge clk_sys);
    $display("txn async_reset: outputs at reset values checked");

    // CLKFX stop indication while running.
    rst_n = 1'b1;
    bus_if.dcm_locked = 1'b1;
    wait_ready(60);
    chk("stop_pre_ready", bus_if.ready, 1);
    @(negedge clk_sys);
    bus_if.dcm_status = 8'h04;
    repeat (5) @(negedge clk_sys);
    chk("stop_ready", bus_if.ready, STOP_EN ? 0 : 1);
    chk("stop_retry_count", bus_if.retry_count, STOP_EN ? 1 : 0);
    bus_if.dcm_status = 8'h00;
    repeat (4) @(negedge clk_sys);
    $display("txn clkfx_stop: stop_detect=%0d ready=%0d", STOP_EN, bus_if.ready);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
